iir_biquad_cascade: RTL and testbench
=====================================

Name: iir_biquad_cascade

Overview:
- Time-multiplexed cascade of SECTIONS direct-form-I biquads that share one N x N multiplier and one accumulator.
- Successor to the single-section filter: adds a section count parameter, a coefficient register file, a valid/busy handshake, rounding, and optional saturation.
- Sits between the sample source (ADC/decimator) and downstream processing.
- Per section: y = a0*x + a1*x1 + a2*x2 + b1*y1 + b2*y2. The b coefficients are stored pre-negated.

Parameters:
- N, 16, sample and coefficient width, signed two's complement.
- SECTIONS, 2, number of cascaded biquads, range 1..8.
- COEF_FRAC, 14, fractional bits of the coefficients (Q2.14 at default).
- ACC_W, 2*N+4, accumulator width. Guard bits cover 5 products.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- en  in  1  sample strobe; x_in is valid when en is high
- x_in  in  N  signed input sample
- coef_we  in  1  coefficient write strobe
- coef_addr  in  $clog2(5*SECTIONS)  address = section*5 + k, with k = 0:a0, 1:a1, 2:a2, 3:b1, 4:b2
- coef_data  in  N  signed coefficient value
- y_out  out  N  signed output of the last section, held between results
- y_valid  out  1  one-cycle pulse when y_out updates
- busy  out  1  high from the cycle after en is accepted until the cycle y_valid pulses
- drop  out  1  sticky; set when a sample or coefficient write is rejected; cleared only by rst

Behaviour:
- Reset: y_out=0, y_valid=0, busy=0, drop=0, FSM=IDLE. All section histories (x1, x2, y1, y2) and the accumulator clear to 0. Coefficients reset to 0.
- FSM states: IDLE -> MAC -> WB -> (MAC of next section | DONE) -> IDLE.
- IDLE: when en=1, latch x_in as the section-0 input, set section index s=0 and k=0, go to MAC.
- MAC: five cycles, k = 0..4. Each cycle does acc += sample[k]*coef[s*5+k]. The accumulator clears on entry to section s.
- WB: one cycle.
  - y_s = (acc + 2^(COEF_FRAC-1)) >>> COEF_FRAC, i.e. round half up (arithmetic).
  - Reduce y_s to N bits (see Optional Feature).
  - Update state: x2<=x1, x1<=x_s, y2<=y1, y1<=y_s.
  - y_s becomes the input x of section s+1.
  - If s=SECTIONS-1, go to DONE; otherwise s++ and go to MAC.
- DONE: y_out<=y_last, y_valid=1 for this one cycle, busy deasserts, return to IDLE.
- Latency: y_valid is high in the cycle starting at edge 6*SECTIONS+1 after the edge that sampled en (edge 13 for SECTIONS=2).
- Throughput: one sample per 6*SECTIONS+2 cycles. en in the DONE cycle is rejected. en in the first IDLE cycle after DONE is accepted.
- en while busy: the sample is discarded, drop<=1, and the computation in progress is unaffected.
- coef_we while busy: the write is ignored and drop<=1. In IDLE the write takes effect at the next edge.
- coef_we with an out-of-range address (>= 5*SECTIONS) is ignored and does not set drop.
- Simultaneous en and coef_we in IDLE: the write lands first, and the accepted sample uses the new coefficient.
- rst mid-computation: abort immediately and go to reset values. No y_valid is produced.
- Products are full 2N-bit signed and sign-extended into ACC_W. The accumulator never wraps for |coef| <= 2^(N-1).

Optional Feature:
- Macro IIR_SAT_EN.
- Defined: each WB result outside [-2^(N-1), 2^(N-1)-1] clamps to the nearest limit.
- Not defined: truncate to the low N bits (two's-complement wrap).
- Rounding is identical in both builds.

Decomposition:
- Package iir_pkg holds:
  - state enum {IDLE, MAC, WB, DONE};
  - coefficient index constants K_A0..K_B2 = 0..4;
  - localparam TAPS=5;
  - round/saturate function parameterised by N, COEF_FRAC, ACC_W.
- One sub-module, iir_mac_unit: multiplier, accumulator, clear/accumulate control, and WB round/reduce output. The top level holds the FSM, coefficient file and section histories.

Test Plan:
- Reset, then idle: all outputs 0; en with x_in=500 and all coefficients 0 -> y_valid at edge 13, y_out=0.
- SECTIONS=2, both sections a0=0x4000, other coefficients 0: x_in=1000 -> y_out=1000 after 13 cycles; x_in=-1234 -> -1234.
- SECTIONS=1, a0=0x4000, b1=0x2000: impulse 1000,0,0,0 -> y_out=1000, 500, 250, 125, then 63 (round half up).
- SECTIONS=1, a0=0x7FFF, x_in=30000 -> y_out=32767 with IIR_SAT_EN; -5538 without it.
- en pulsed at edge 3 of a computation and coef_we while busy -> sample and write dropped, drop=1, result unchanged; the next sample is accepted one cycle after y_valid.
- rst asserted mid-MAC -> no y_valid, histories cleared; the next impulse reproduces the first-sample response exactly.

Source files
------------

// File: rtl/iir_pkg.sv
// rtl/iir_pkg.sv - shared types, tap indices and round/reduce helper for the biquad cascade
package iir_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MAC  = 2'd1,
        WB   = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam int TAPS = 5;
    localparam int K_A0 = 0;
    localparam int K_A1 = 1;
    localparam int K_A2 = 2;
    localparam int K_B1 = 3;
    localparam int K_B2 = 4;

    // Round half up then optionally clamp to n-bit signed range; caller keeps the low n bits.
    function automatic logic signed [63:0] round_reduce(
        input logic signed [63:0] acc,
        input int                 n,
        input int                 frac,
        input logic               sat
    );
        logic signed [63:0] r;
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        r  = (acc + (64'sd1 <<< (frac - 1))) >>> frac;
        hi = (64'sd1 <<< (n - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (n - 1));
        if (sat && (r > hi)) begin
            r = hi;
        end else if (sat && (r < lo)) begin
            r = lo;
        end
        return r;
    endfunction

endpackage

// File: rtl/iir_mac_unit.sv
// rtl/iir_mac_unit.sv - shared multiplier/accumulator with round and N-bit reduce
// IIR_SAT_EN: clamp out-of-range results instead of wrapping.
module iir_mac_unit
    import iir_pkg::*;
#(
    parameter int N         = 16,
    parameter int COEF_FRAC = 14,
    parameter int ACC_W     = 2*N+4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                mac_i,
    input  logic                first_i,
    input  logic signed [N-1:0] sample_i,
    input  logic signed [N-1:0] coef_i,
    output logic signed [N-1:0] y_o
);

`ifdef IIR_SAT_EN
    localparam logic SAT = 1'b1;
`else
    localparam logic SAT = 1'b0;
`endif

    logic signed [2*N-1:0]   prod;
    logic signed [ACC_W-1:0] prod_ext;
    logic signed [ACC_W-1:0] acc_q;
    logic signed [ACC_W-1:0] acc_d;

    assign prod     = sample_i * coef_i;
    assign prod_ext = {{(ACC_W-2*N){prod[2*N-1]}}, prod};

    // The first tap of a section overwrites the accumulator rather than adding to it.
    always_comb begin
        acc_d = acc_q;
        if (mac_i) begin
            acc_d = (first_i ? '0 : acc_q) + prod_ext;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

    assign y_o = N'(round_reduce(64'(acc_q), N, COEF_FRAC, SAT));

endmodule

// File: rtl/iir_biquad_cascade.sv
// rtl/iir_biquad_cascade.sv - time-multiplexed direct-form-I biquad cascade with coefficient file
// IIR_SAT_EN (in iir_mac_unit) selects clamping over wrap on each section result.
module iir_biquad_cascade
    import iir_pkg::*;
#(
    parameter int N         = 16,
    parameter int SECTIONS  = 2,
    parameter int COEF_FRAC = 14,
    parameter int ACC_W     = 2*N+4
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               en,
    input  logic [N-1:0]                       x_in,
    input  logic                               coef_we,
    input  logic [$clog2(TAPS*SECTIONS)-1:0]   coef_addr,
    input  logic [N-1:0]                       coef_data,
    output logic [N-1:0]                       y_out,
    output logic                               y_valid,
    output logic                               busy,
    output logic                               drop
);

    localparam int NC  = TAPS * SECTIONS;
    localparam int CAW = $clog2(NC);
    localparam int SW  = (SECTIONS > 1) ? $clog2(SECTIONS) : 1;

    state_t state_q, state_d;

    logic [SW-1:0]       s_q;
    logic [2:0]          k_q;
    logic signed [N-1:0] coef_q [NC];
    logic signed [N-1:0] x1_q [SECTIONS];
    logic signed [N-1:0] x2_q [SECTIONS];
    logic signed [N-1:0] y1_q [SECTIONS];
    logic signed [N-1:0] y2_q [SECTIONS];
    logic signed [N-1:0] x_cur_q;
    logic [N-1:0]        y_out_q;
    logic                y_valid_q;
    logic                drop_q;

    logic                last_sec;
    logic                wr_hit;
    logic [CAW-1:0]      coef_idx;
    logic signed [N-1:0] sample;
    logic signed [N-1:0] mac_y;
    logic                mac_en;
    logic                mac_first;

    assign last_sec = (int'(s_q) == SECTIONS - 1);
    assign wr_hit   = coef_we && (int'(coef_addr) < NC);
    assign coef_idx = CAW'(int'(s_q) * TAPS + int'(k_q));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (en) state_d = MAC;
            MAC:     if (k_q == 3'(K_B2)) state_d = WB;
            WB:      state_d = last_sec ? DONE : MAC;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy      = (state_q != IDLE);
        mac_en    = (state_q == MAC);
        mac_first = (k_q == 3'(K_A0));
    end

    always_comb begin
        sample = '0;
        case (int'(k_q))
            K_A0:    sample = x_cur_q;
            K_A1:    sample = x1_q[s_q];
            K_A2:    sample = x2_q[s_q];
            K_B1:    sample = y1_q[s_q];
            K_B2:    sample = y2_q[s_q];
            default: sample = '0;
        endcase
    end

    iir_mac_unit #(
        .N         (N),
        .COEF_FRAC (COEF_FRAC),
        .ACC_W     (ACC_W)
    ) u_mac (
        .clk      (clk),
        .rst      (rst),
        .mac_i    (mac_en),
        .first_i  (mac_first),
        .sample_i (sample),
        .coef_i   (coef_q[coef_idx]),
        .y_o      (mac_y)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            s_q       <= '0;
            k_q       <= '0;
            x_cur_q   <= '0;
            y_out_q   <= '0;
            y_valid_q <= 1'b0;
            drop_q    <= 1'b0;
            for (int i = 0; i < NC; i++) begin
                coef_q[i] <= '0;
            end
            for (int i = 0; i < SECTIONS; i++) begin
                x1_q[i] <= '0;
                x2_q[i] <= '0;
                y1_q[i] <= '0;
                y2_q[i] <= '0;
            end
        end else begin
            y_valid_q <= (state_q == DONE);
            // Anything that arrives outside IDLE is rejected without touching the running sample.
            if ((en || wr_hit) && (state_q != IDLE)) begin
                drop_q <= 1'b1;
            end
            if (wr_hit && (state_q == IDLE)) begin
                coef_q[coef_addr] <= coef_data;
            end
            case (state_q)
                IDLE: begin
                    if (en) begin
                        x_cur_q <= x_in;
                        s_q     <= '0;
                        k_q     <= '0;
                    end
                end
                MAC: begin
                    k_q <= k_q + 3'd1;
                end
                WB: begin
                    x2_q[s_q] <= x1_q[s_q];
                    x1_q[s_q] <= x_cur_q;
                    y2_q[s_q] <= y1_q[s_q];
                    y1_q[s_q] <= mac_y;
                    x_cur_q   <= mac_y;
                    k_q       <= '0;
                    if (!last_sec) begin
                        s_q <= s_q + 1'b1;
                    end
                end
                DONE: begin
                    y_out_q <= x_cur_q;
                end
                default: begin
                end
            endcase
        end
    end

    assign y_out   = y_out_q;
    assign y_valid = y_valid_q;
    assign drop    = drop_q;

endmodule

// File: tb/tb_iir_biquad_cascade.sv
// tb/tb_iir_biquad_cascade.sv - directed self-checking bench for iir_biquad_cascade (SECTIONS=2)
module tb_iir_biquad_cascade;

    localparam int N   = 16;
    localparam int S   = 2;
    localparam int NC  = 10;
    localparam int AW  = 4;
    localparam int INF = 1 << 30;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          en = 1'b0;
    logic [N-1:0]  x_in = '0;
    logic          coef_we = 1'b0;
    logic [AW-1:0] coef_addr = '0;
    logic [N-1:0]  coef_data = '0;
    logic [N-1:0]  y_out;
    logic          y_valid;
    logic          busy;
    logic          drop;

    iir_biquad_cascade #(.N(N), .SECTIONS(S)) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .x_in      (x_in),
        .coef_we   (coef_we),
        .coef_addr (coef_addr),
        .coef_data (coef_data),
        .y_out     (y_out),
        .y_valid   (y_valid),
        .busy      (busy),
        .drop      (drop)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_tests = 0;
    int n_fail  = 0;
    int acc_e, prev_e, pend_y, prev_y, cur_y, drop_cyc;
    int mcoef [NC];
    int mx1 [S];
    int mx2 [S];
    int my1 [S];
    int my2 [S];

    task automatic chk(input string name, input int got, input int exp);
        n_tests++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    function automatic void model_clear();
        for (int i = 0; i < NC; i++) mcoef[i] = 0;
        for (int i = 0; i < S; i++) begin
            mx1[i] = 0; mx2[i] = 0; my1[i] = 0; my2[i] = 0;
        end
        acc_e = -100; prev_e = -100; pend_y = 0; prev_y = 0; drop_cyc = INF;
    endfunction

    // Plain-arithmetic cascade: each section's rounded, reduced output feeds the next.
    function automatic int model_run(input int x_first);
        longint acc, r;
        int x;
        x = x_first;
        for (int s = 0; s < S; s++) begin
            acc = longint'(mcoef[s*5+0]) * x + longint'(mcoef[s*5+1]) * mx1[s]
                + longint'(mcoef[s*5+2]) * mx2[s] + longint'(mcoef[s*5+3]) * my1[s]
                + longint'(mcoef[s*5+4]) * my2[s];
            r = (acc + 8192) >>> 14;
`ifdef IIR_SAT_EN
            if (r > 32767) r = 32767;
            if (r < -32768) r = -32768;
`else
            r = longint'(shortint'(r));
`endif
            mx2[s] = mx1[s]; mx1[s] = x;
            my2[s] = my1[s]; my1[s] = int'(r);
            x = int'(r);
        end
        return x;
    endfunction

    task automatic check_cycle();
        bit v;
        if (rst) begin
            cur_y = 0;
            return;
        end
        v = 1'b0;
        if (cyc == acc_e + 14) begin
            v = 1'b1; cur_y = pend_y;
        end else if (cyc == prev_e + 14) begin
            v = 1'b1; cur_y = prev_y;
        end
        chk("y_valid", int'(y_valid), int'(v));
        chk("y_out", int'($signed(y_out)), cur_y);
        chk("busy", int'(busy), int'(cyc >= acc_e + 1 && cyc <= acc_e + 13));
        chk("drop", int'(drop), int'(cyc >= drop_cyc));
    endtask

    task automatic tick();
        @(negedge clk);
        check_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input bit do_en, input int x, input bit do_we, input int addr, input int data);
        bit idle;
        idle      = (cyc >= acc_e + 14);
        en        = do_en;
        x_in      = N'(x);
        coef_we   = do_we;
        coef_addr = AW'(addr);
        coef_data = N'(data);
        if (do_we && addr < NC) begin
            if (idle) mcoef[addr] = int'(shortint'(data));
            else if (drop_cyc > cyc + 1) drop_cyc = cyc + 1;
        end
        if (do_en) begin
            if (idle) begin
                prev_e = acc_e; prev_y = pend_y;
                pend_y = model_run(x);
                acc_e  = cyc;
            end else if (drop_cyc > cyc + 1) begin
                drop_cyc = cyc + 1;
            end
        end
        tick();
        en = 1'b0;
        coef_we = 1'b0;
    endtask

    task automatic wr(input int addr, input int data);
        drive(1'b0, 0, 1'b1, addr, data);
    endtask

    task automatic send(input int x);
        drive(1'b1, x, 1'b0, 0, 0);
    endtask

    task automatic wait_valid(input string name, input int lit);
        int k;
        k = 0;
        while (!y_valid && k < 40) begin
            tick();
            k++;
        end
        if (!y_valid) begin
            chk({name, "_timeout"}, 0, 1);
        end else begin
            chk(name, int'($signed(y_out)), lit);
            chk({name, "_model"}, pend_y, lit);
            chk({name, "_latency"}, cyc - (acc_e + 1), 13);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        model_clear();
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic load_impulse_coefs();
        wr(0, 16384);
        wr(3, 8192);
        wr(5, 16384);
    endtask

    int imp [5] = '{1000, 500, 250, 125, 63};

    initial begin
        model_clear();
        repeat (3) tick();
        rst = 1'b0;
        tick();
        chk("rst_y_out", int'(y_out), 0);
        chk("rst_y_valid", int'(y_valid), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_drop", int'(drop), 0);

        send(500);
        wait_valid("zero_coef", 0);

        wr(0, 16384);
        wr(5, 16384);
        send(1000);
        wait_valid("pass_pos", 1000);
        send(-1234);
        wait_valid("pass_neg", -1234);

        do_reset();
        load_impulse_coefs();
        for (int i = 0; i < 5; i++) begin
            send(i == 0 ? 1000 : 0);
            wait_valid($sformatf("impulse%0d", i), imp[i]);
        end

        send(0);
        tick();
        send(7777);
        wr(3, 0);
        wait_valid("drop_result", 32);
        chk("drop_flag", int'(drop), 1);
        send(0);
        wait_valid("after_drop", 16);

        do_reset();
        load_impulse_coefs();
        send(1000);
        wait_valid("pre_rst", 1000);
        send(0);
        tick();
        do_reset();
        chk("abort_busy", int'(busy), 0);
        repeat (20) tick();
        load_impulse_coefs();
        send(1000);
        wait_valid("post_rst0", 1000);
        send(0);
        wait_valid("post_rst1", 500);

        do_reset();
        wr(0, 32767);
        wr(5, 16384);
        send(30000);
        wr(12, 5);
`ifdef IIR_SAT_EN
        wait_valid("sat_big", 32767);
`else
        wait_valid("wrap_big", -5538);
`endif
        chk("oor_nodrop", int'(drop), 0);
        drive(1'b1, 100, 1'b1, 0, 16384);
        wait_valid("write_first", 100);

        repeat (3) tick();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
